fp16_add_sequencer: RTL

Multi-cycle FP16 (IEEE-754 binary16) add/subtract engine built around one shared alignment, add and normalize datapath, driven by an FSM.
- Accepts one operation at a time over a valid/ready handshake.
- Normalizes iteratively, one bit per cycle, instead of using a full leading-zero shifter.
- Rounds, then holds the result until the consumer accepts it.
- Sits between the register-file/issue logic and writeback in the FP16 adder path.

---
 rtl/fp16_pkg.sv | 46 ++++
 rtl/fp16_align_shifter.sv | 26 ++
 rtl/fp16_add_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 constants, state encoding and payload types for the FP16 add path.
// Contents: field widths, special encodings, FSM state enum, unpacked-operand
// and flag structs, and a decode helper that maps an FP16 word to its
// effective exponent / significand form.
package fp16_pkg;

    localparam int unsigned EXP_W   = 5;
    localparam int unsigned MAN_W   = 10;
    localparam int unsigned SIG_W   = MAN_W + 1;      // significand incl. hidden bit
    localparam int unsigned BIAS    = 15;
    localparam int unsigned EXP_MAX = 2 * BIAS + 1;   // all-ones exponent field (31)
    localparam logic [15:0] QNAN    = 16'h7E00;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } seqState;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;    // effective exponent, 1 for subnormals
        logic [SIG_W-1:0] mant;   // hidden bit + fraction
    } unpackedOp;

    typedef struct packed {
        logic overflow;
        logic invalid;
        logic inexact;
    } fpFlags;

    // Subnormals share exponent 1 with the smallest normals but carry hidden=0.
    function automatic unpackedOp unpackFp16(input logic [15:0] x);
        unpackedOp u;
        logic      isNorm;
        isNorm = (x[14:10] != '0);
        u.sign = x[15];
        u.exp  = isNorm ? x[14:10] : EXP_W'(1);
        u.mant = {isNorm, x[9:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp16_align_shifter.sv
// Combinational right shifter for operand alignment, folding every bit that
// falls off the bottom into the LSB as a sticky bit.
// Ports:
//   sigIn     - significand with guard/round/sticky positions appended
//   shiftAmt  - right shift amount, 0..31 (amounts >= width keep only sticky)
//   shifted_c - aligned significand, LSB is OR'ed with all discarded bits
module fp16_align_shifter #(
    parameter int unsigned W = 14
) (
    input  logic [W-1:0] sigIn,
    input  logic [4:0]   shiftAmt,
    output logic [W-1:0] shifted_c
);

    logic [W-1:0] keepMask;
    logic         sticky;

    // Bits below keepMask are the ones shifted out; their OR becomes sticky.
    always_comb begin
        keepMask     = {W{1'b1}} << shiftAmt;
        sticky       = |(sigIn & ~keepMask);
        shifted_c    = sigIn >> shiftAmt;
        shifted_c[0] = shifted_c[0] | sticky;
    end

endmodule

// File: rtl/fp16_add_sequencer.sv
// Multi-cycle FP16 add/subtract engine: one shared align / add / normalize /
// round datapath sequenced by an FSM, with one-bit-per-cycle normalization.
// Ports:
//   clk, rst_n                - clock, async active-low reset
//   in_valid / in_ready       - operation request handshake (ready only in IDLE)
//   op_a, op_b, op_sub        - operands; op_sub inverts B's sign at capture
//   out_valid / out_ready     - result handshake; result held until accepted
//   result                    - FP16 result
//   flag_overflow/invalid/inexact - exception flags for the held result
//   busy                      - engine is not idle
module fp16_add_sequencer
    import fp16_pkg::*;
#(
    parameter int unsigned ROUND_MODE = 0,
    parameter int unsigned GRS_W      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        op_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        flag_overflow,
    output logic        flag_invalid,
    output logic        flag_inexact,
    output logic        busy
);

    localparam int unsigned ALN_W  = SIG_W + GRS_W;   // significand + G/R/S
    localparam int unsigned SUM_W  = ALN_W + 1;       // plus carry
    localparam int unsigned MSB    = ALN_W - 1;       // hidden-bit position in sum
    localparam int unsigned XEXP_W = EXP_W + 1;       // room for exponent overflow
    localparam int unsigned RND_W  = SIG_W + 1;

    seqState state, stateNext;

    logic        inReadyQ, outValidQ, busyQ;
    logic [15:0] resultQ;
    fpFlags      flagsQ;

    // captured operands (B already sign-adjusted)
    logic [15:0] capA, capB;

    // alignment results
    logic [ALN_W-1:0]  bigSig, smallSig;
    logic [XEXP_W-1:0] expW;
    logic              signBig, effSub, zeroSign;
    logic              specialQ, specialInvQ;
    logic [15:0]       specialResQ;

    // working sum: carry | significand | G R S
    logic [SUM_W-1:0] sum;

    // ALIGN combinational signals
    unpackedOp        upA, upB, opBig, opSmall;
    logic             aNan, bNan, aInf, bInf, aGe;
    logic             specialHit, specialInv;
    logic [15:0]      specialRes;
    logic [EXP_W-1:0] expDiff;
    logic [ALN_W-1:0] smallAligned;

    // ADD / NORM / ROUND combinational signals
    logic [SUM_W-1:0]  sumNext;
    logic              sumZero, normCarry, normShiftL;
    logic [SIG_W-1:0]  mantPre, mantFin;
    logic [RND_W-1:0]  mantInc;
    logic              guardBit, lowBits, grsAny, roundUp;
    logic [XEXP_W-1:0] expFin;
    logic [EXP_W-1:0]  expField;
    logic              overflowHit, resSign;
    logic [15:0]       roundRes;

    assign in_ready      = inReadyQ;
    assign out_valid     = outValidQ;
    assign busy          = busyQ;
    assign result        = resultQ;
    assign flag_overflow = flagsQ.overflow;
    assign flag_invalid  = flagsQ.invalid;
    assign flag_inexact  = flagsQ.inexact;

    // Decode, special-case detection and magnitude ordering of captured operands.
    always_comb begin
        upA  = unpackFp16(capA);
        upB  = unpackFp16(capB);
        aInf = (capA[14:10] == EXP_W'(EXP_MAX)) && (capA[9:0] == '0);
        bInf = (capB[14:10] == EXP_W'(EXP_MAX)) && (capB[9:0] == '0);
        aNan = (capA[14:10] == EXP_W'(EXP_MAX)) && (capA[9:0] != '0);
        bNan = (capB[14:10] == EXP_W'(EXP_MAX)) && (capB[9:0] != '0);

        specialHit = aNan | bNan | aInf | bInf;
        specialInv = aNan | bNan | (aInf & bInf & (capA[15] != capB[15]));
        if (specialInv) begin
            specialRes = QNAN;
        end else if (aInf) begin
            specialRes = capA;
        end else begin
            specialRes = capB;
        end

        aGe     = {upA.exp, upA.mant} >= {upB.exp, upB.mant};
        opBig   = aGe ? upA : upB;
        opSmall = aGe ? upB : upA;
        expDiff = opBig.exp - opSmall.exp;
    end

    fp16_align_shifter #(
        .W(ALN_W)
    ) u_alignShifter (
        .sigIn    ({opSmall.mant, {GRS_W{1'b0}}}),
        .shiftAmt (expDiff),
        .shifted_c(smallAligned)
    );

    // Magnitude add/subtract; the larger operand is first so the result is non-negative.
    always_comb begin
        if (effSub) begin
            sumNext = {1'b0, bigSig} - {1'b0, smallSig};
        end else begin
            sumNext = {1'b0, bigSig} + {1'b0, smallSig};
        end
    end

    // Normalization decisions; left shifts stop at exponent 1 to form subnormals.
    always_comb begin
        sumZero    = (sum == '0);
        normCarry  = sum[SUM_W-1];
        normShiftL = !normCarry && !sumZero && !sum[MSB] && (expW > XEXP_W'(1));
    end

    // Rounding, exponent fix-up after mantissa overflow, and result packing.
    always_comb begin
        mantPre  = sum[MSB -: SIG_W];
        guardBit = sum[GRS_W-1];
        lowBits  = |sum[GRS_W-2:0];
        grsAny   = guardBit | lowBits;
        roundUp  = (ROUND_MODE == 0) ? (guardBit & (lowBits | mantPre[0])) : 1'b0;
        mantInc  = {1'b0, mantPre} + RND_W'(roundUp);

        if (mantInc[SIG_W]) begin
            mantFin = mantInc[SIG_W:1];
            expFin  = expW + XEXP_W'(1);
        end else begin
            mantFin = mantInc[SIG_W-1:0];
            expFin  = expW;
        end

        overflowHit = (expFin >= XEXP_W'(EXP_MAX));
        resSign     = sumZero ? zeroSign : signBig;
        // hidden bit clear only for subnormals and zero, which encode exponent 0
        expField    = mantFin[MAN_W] ? expFin[EXP_W-1:0] : '0;

        if (overflowHit) begin
            if (ROUND_MODE == 0) begin
                roundRes = {resSign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                roundRes = {resSign, EXP_W'(EXP_MAX - 1), {MAN_W{1'b1}}};
            end
        end else begin
            roundRes = {resSign, expField, mantFin[MAN_W-1:0]};
        end
    end

    // State register plus registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            state     <= stateNext;
            inReadyQ  <= (stateNext == IDLE);
            outValidQ <= (stateNext == DONE);
            busyQ     <= (stateNext != IDLE);
        end
    end

    // Next-state logic. Specials pass through ROUND so the result register
    // has a single load point.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (in_valid) stateNext = ALIGN;
            ALIGN:   stateNext = specialHit ? ROUND : ADD;
            ADD:     stateNext = NORM;
            NORM:    if (!normShiftL) stateNext = ROUND;
            ROUND:   stateNext = DONE;
            DONE:    if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath registers, loaded according to the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capA        <= '0;
            capB        <= '0;
            bigSig      <= '0;
            smallSig    <= '0;
            expW        <= '0;
            signBig     <= 1'b0;
            effSub      <= 1'b0;
            zeroSign    <= 1'b0;
            specialQ    <= 1'b0;
            specialInvQ <= 1'b0;
            specialResQ <= '0;
            sum         <= '0;
            resultQ     <= '0;
            flagsQ      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        capA   <= op_a;
                        capB   <= {op_b[15] ^ op_sub, op_b[14:0]};
                        flagsQ <= '0;
                    end
                end
                ALIGN: begin
                    bigSig      <= {opBig.mant, {GRS_W{1'b0}}};
                    smallSig    <= smallAligned;
                    expW        <= {1'b0, opBig.exp};
                    signBig     <= opBig.sign;
                    effSub      <= (opBig.sign != opSmall.sign);
                    zeroSign    <= capA[15] & capB[15];
                    specialQ    <= specialHit;
                    specialInvQ <= specialInv;
                    specialResQ <= specialRes;
                end
                ADD: begin
                    sum <= sumNext;
                end
                NORM: begin
                    if (normCarry) begin
                        sum  <= {1'b0, sum[SUM_W-1:2], |sum[1:0]};
                        expW <= expW + XEXP_W'(1);
                    end else if (normShiftL) begin
                        sum  <= {sum[SUM_W-2:0], 1'b0};
                        expW <= expW - XEXP_W'(1);
                    end
                end
                ROUND: begin
                    if (specialQ) begin
                        resultQ <= specialResQ;
                        flagsQ  <= '{overflow: 1'b0, invalid: specialInvQ, inexact: 1'b0};
                    end else begin
                        resultQ <= roundRes;
                        flagsQ  <= '{overflow: overflowHit, invalid: 1'b0,
                                     inexact: overflowHit | grsAny};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
